mod_addsub_arbiter: RTL
=======================

# mod_addsub_arbiter

Shared-resource arbiter for the secp256k1 field datapath: N requesters (point-add/double sequencers, inverse engine) time-share one modular add/subtract unit over GF(p), p = 2^256 − 2^32 − 977. Requests are accepted with a valid/ready handshake under round-robin priority, computed in one pass through a combinational mod add/sub core, and returned through a one-entry registered response slot tagged with the requester index. Sits between the curve-level sequencers and the field arithmetic layer.

## Interface
- N_REQ, default 4: number of requesters (2..8).
- W, default 256: operand width; fixed to 256 for secp256k1.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester accept; at most one bit high per cycle.
- req_op  in  N_REQ  per-requester op: 0 = sub (x − y mod p), 1 = add (x + y mod p).
- req_x  in  N_REQ*W  operand x, requester i at bits [i*W +: W].
- req_y  in  N_REQ*W  operand y, same packing.
- resp_valid  out  1  response slot occupied.
- resp_ready  in  1  consumer accepts response.
- resp_id  out  $clog2(N_REQ)  index of requester that owns resp_data.
- resp_data  out  W  result, in [0, p) for reduced inputs.
- op_count  out  32  count of accepted requests, wraps at 2^32.

## Operation
- Operands are required to be reduced (< p). For unreduced operands the result equals the formulas below taken mod 2^256, not a reduced value.
- Sub: d = x − y (257-bit with borrow); if borrow, d = d + p mod 2^256. Add: s = x + y (257-bit); if s ≥ p, s = s − p.
- Slot free condition: slot_free = !resp_valid || resp_ready.
- Grant: when slot_free, the first asserted req_valid at or after index (last_grant + 1) mod N_REQ is granted; req_ready is high only for that index, combinationally.
- Accept (req_valid[i] && req_ready[i]): result, i, and resp_valid = 1 load into the slot at the next edge; last_grant ← i; op_count increments.
- Response consumed (resp_valid && resp_ready) with no new accept: resp_valid ← 0. resp_data and resp_id hold their last values.
- Simultaneous consume and accept: the slot reloads, resp_valid stays 1, with no bubble.
- When no request is valid, last_grant is unchanged.
- Stall (resp_valid && !resp_ready): all req_ready = 0. resp_data and resp_id stay stable.
- req_ready does not depend on the requester's own req_valid for other indices. A requester must hold valid, op and operands stable until accepted.

## Timing
- Reset values: resp_valid 0, resp_data 0, resp_id 0, op_count 0, last_grant N_REQ−1 (requester 0 has first priority). req_ready is 0 while rst is high.
- Reset mid-operation: a pending response is discarded, and no accept occurs in the reset cycle.
- Latency: accept at edge k, resp_valid visible after edge k. One request per cycle sustained when resp_ready = 1.
- Fairness: with all N_REQ requesting continuously, each is granted exactly once per N_REQ consecutive accepts.
- Critical path: 257-bit add/sub, compare, and correction in one cycle. Retiming is outside this block's scope.

## Structure
- Package secp256k1_pkg holds the constants P (256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F), OP_SUB = 1'b0 and OP_ADD = 1'b1.
- Sub-module mod_addsub (combinational): inputs x, y, op; output r. It implements the correct borrow/carry-based reduction above. The arbiter instantiates it once, fed by muxed operands of the granted requester.
- The arbiter contains the round-robin pointer, grant logic, response slot, and op_count.

## Test plan
- Requester 0 sub x=5, y=3 → resp_data=2, resp_id=0 one cycle after accept; op_count=1.
- Requester 1 sub x=3, y=5 → resp_data=p−2=…FFFFFC2D; requester 2 add x=p−1, y=2 → resp_data=1; add x=p−1, y=1 → resp_data=0.
- All 4 requesters valid continuously with resp_ready=1 → grants 0,1,2,3,0,1 on consecutive cycles with no bubbles; resp_id follows the same sequence.
- resp_ready held 0 for 3 cycles while 2 requesters wait → resp_valid/resp_data/resp_id stable and req_ready=0. On release, the next grant occurs in the same cycle as the consume and resp_valid stays 1.
- Only requester 3 valid after last grant 3 → requester 3 is granted again. The pointer skips idle requesters without losing a cycle.
- Assert rst asynchronously mid-edge while resp_valid=1 → outputs go to reset values immediately. After release, requester 0 wins a tie against requester 2.

Source files
------------

// File: rtl/secp256k1_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : secp256k1_pkg
//  Description : Field constants shared by the secp256k1 add/sub datapath.
//                P     - field prime 2^256 - 2^32 - 977
//                OP_*  - operation encoding carried on req_op
//  Revision    : 1.0  initial release
// ============================================================================
package secp256k1_pkg;

    localparam logic [255:0] P =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

    localparam logic OP_SUB = 1'b0;
    localparam logic OP_ADD = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mod_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : mod_addsub
//  Description : Combinational modular add/subtract over GF(P).
//                op = OP_ADD : r = x + y, minus P once if the sum reaches P
//                op = OP_SUB : r = x - y, plus P once if the difference borrows
//                Results are in [0, P) only when x and y are already reduced.
//  Ports       : x  [W-1:0] in   operand x
//                y  [W-1:0] in   operand y
//                op         in   OP_SUB / OP_ADD
//                r  [W-1:0] out  result
//  Revision    : 1.0  initial release
// ============================================================================
module mod_addsub
    import secp256k1_pkg::*;
#(
    parameter int W = 256
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         op,
    output logic [W-1:0] r
);

    localparam logic [W:0] c_p_ext = (W+1)'(P);

    logic [W:0]   w_sum;
    logic [W:0]   w_diff;
    logic [W:0]   w_sum_corr;
    logic [W-1:0] w_diff_corr;

    // One extra bit on both paths: carry-out for add, borrow flag for sub.
    assign w_sum       = {1'b0, x} + {1'b0, y};
    assign w_diff      = {1'b0, x} - {1'b0, y};
    assign w_sum_corr  = w_sum - c_p_ext;
    // Adding P wraps mod 2^W, which is exactly the borrow correction.
    assign w_diff_corr = w_diff[W-1:0] + c_p_ext[W-1:0];

    always_comb begin
        r = '0;
        if (op == OP_ADD) begin
            r = (w_sum >= c_p_ext) ? w_sum_corr[W-1:0] : w_sum[W-1:0];
        end else begin
            r = w_diff[W] ? w_diff_corr : w_diff[W-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/mod_addsub_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mod_addsub_arbiter
//  Description : Round-robin arbiter sharing one mod_addsub unit between
//                N_REQ requesters. The granted request is computed in the
//                same cycle and lands in a one-entry registered response
//                slot tagged with the requester index.
//  Ports       : clk, rst (async, active high)
//                req_valid/req_ready/req_op [N_REQ]   per-requester handshake
//                req_x/req_y [N_REQ*W]                packed operands
//                resp_valid/resp_ready                response handshake
//                resp_id [$clog2(N_REQ)]              owner of resp_data
//                resp_data [W]                        result
//                op_count [32]                        accepted requests
//  Revision    : 1.0  initial release
// ============================================================================
module mod_addsub_arbiter
    import secp256k1_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int W     = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ-1:0]           req_op,
    input  logic [N_REQ*W-1:0]         req_x,
    input  logic [N_REQ*W-1:0]         req_y,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [$clog2(N_REQ)-1:0]   resp_id,
    output logic [W-1:0]               resp_data,
    output logic [31:0]                op_count
);

    localparam int c_id_w = $clog2(N_REQ);

    logic [c_id_w-1:0] r_last_grant;
    logic              r_resp_valid;
    logic [c_id_w-1:0] r_resp_id;
    logic [W-1:0]      r_resp_data;
    logic [31:0]       r_op_count;

    logic              w_found;
    logic [c_id_w-1:0] w_grant_idx;
    logic [c_id_w:0]   w_idx_tmp;
    logic              w_slot_free;
    logic              w_accept;
    logic [W-1:0]      w_x;
    logic [W-1:0]      w_y;
    logic              w_op;
    logic [W-1:0]      w_result;

    // Search starting one past the last winner. last_grant + 1 + k never
    // exceeds 2*N_REQ - 1, so a single conditional subtract wraps it.
    always_comb begin
        w_found     = 1'b0;
        w_grant_idx = '0;
        w_idx_tmp   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx_tmp = {1'b0, r_last_grant} + (c_id_w+1)'(k + 1);
            if (w_idx_tmp >= (c_id_w+1)'(N_REQ)) begin
                w_idx_tmp = w_idx_tmp - (c_id_w+1)'(N_REQ);
            end
            if (!w_found && req_valid[w_idx_tmp[c_id_w-1:0]]) begin
                w_found     = 1'b1;
                w_grant_idx = w_idx_tmp[c_id_w-1:0];
            end
        end
    end

    assign w_slot_free = !r_resp_valid || resp_ready;
    // Gating with rst keeps req_ready low for the whole reset window, so no
    // requester sees a handshake that the slot will never record.
    assign w_accept    = w_found && w_slot_free && !rst;
    assign req_ready   = w_accept ? (N_REQ'(1) << w_grant_idx) : '0;

    assign w_x  = req_x[w_grant_idx*W +: W];
    assign w_y  = req_y[w_grant_idx*W +: W];
    assign w_op = req_op[w_grant_idx];

    mod_addsub #(
        .W (W)
    ) u_mod_addsub (
        .x  (w_x),
        .y  (w_y),
        .op (w_op),
        .r  (w_result)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= c_id_w'(N_REQ - 1);
            r_resp_valid <= 1'b0;
            r_resp_id    <= '0;
            r_resp_data  <= '0;
            r_op_count   <= '0;
        end else begin
            if (w_accept) begin
                // Covers the consume-and-reload case: valid stays high.
                r_resp_valid <= 1'b1;
                r_resp_id    <= w_grant_idx;
                r_resp_data  <= w_result;
                r_last_grant <= w_grant_idx;
                r_op_count   <= r_op_count + 32'd1;
            end else if (resp_ready) begin
                r_resp_valid <= 1'b0;
            end
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_id    = r_resp_id;
    assign resp_data  = r_resp_data;
    assign op_count   = r_op_count;

endmodule
`default_nettype wire
